vga_timing_gen: RTL and testbench

// - Parametrised raster timing generator; next generation of the fixed 640x480 sync generator.
// - Generates the following from a per-pixel strobe on the system clock:
//   - hsync/vsync with configurable polarity
//   - display enable
//   - pixel position
//   - line-start and frame-start pulses
// - Sits between the clock/reset block and the pixel pipeline / video DAC.
// - All outputs are registered and mutually aligned.

---
 rtl/vga_timing_pkg.sv | 14 +
 rtl/vtg_axis_counter.sv | 32 +++
 rtl/vga_timing_gen.sv | 89 ++++++++
 tb/tb_vga_timing_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster timing, axis descriptor and helpers.
package vga_timing_pkg;
  typedef struct packed {
    int active;
    int front;
    int sync;
    int back;
  } vtg_axis_t;
  localparam vtg_axis_t H_DEFAULT = '{active: 640, front: 16, sync: 96, back: 48};
  localparam vtg_axis_t V_DEFAULT = '{active: 480, front: 10, sync: 2, back: 33};
  function automatic int axis_total(vtg_axis_t a);
    return a.active + a.front + a.sync + a.back;
  endfunction
endpackage

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one raster axis; wrapping position counter with sync/active decode.
module vtg_axis_counter
  import vga_timing_pkg::*;
#(
  parameter vtg_axis_t AX = H_DEFAULT,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_step,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_in_sync,
  output logic         o_in_active
);
  localparam int TOTAL = axis_total(AX);
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LO = W'(AX.active + AX.front);
  localparam logic [W-1:0] SYNC_HI = W'(AX.active + AX.front + AX.sync - 1);
  localparam logic [W-1:0] ACT     = W'(AX.active);
  if (TOTAL > 2 ** W || AX.front < 1 || AX.sync < 1 || AX.back < 1) begin : g_bad
    $error("vtg_axis_counter: total exceeds 2**W or a porch/sync width is < 1");
  end
  logic [W-1:0] r_count;
  assign o_count     = r_count;
  assign o_wrap      = r_count == LAST;
  assign o_in_sync   = r_count >= SYNC_LO && r_count <= SYNC_HI;
  assign o_in_active = r_count < ACT;
  always_ff @(posedge clk)
    if (rst) r_count <= '0;
    else if (i_step) r_count <= o_wrap ? '0 : r_count + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with registered, aligned outputs.
// Define VTG_FRAME_COUNT_EN to add the frame_cnt_o frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = H_DEFAULT.active,
  parameter int H_FRONT     = H_DEFAULT.front,
  parameter int H_SYNC      = H_DEFAULT.sync,
  parameter int H_BACK      = H_DEFAULT.back,
  parameter int V_ACTIVE    = V_DEFAULT.active,
  parameter int V_FRONT     = V_DEFAULT.front,
  parameter int V_SYNC      = V_DEFAULT.sync,
  parameter int V_BACK      = V_DEFAULT.back,
  parameter bit H_SYNC_POL  = 1'b0,
  parameter bit V_SYNC_POL  = 1'b0,
  parameter int POS_W       = 10,
  parameter int FRAME_CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pix_en_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [POS_W-1:0] hpos_o,
  output logic [POS_W-1:0] vpos_o,
  output logic             line_start_o,
`ifdef VTG_FRAME_COUNT_EN
  output logic             frame_start_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
`else
  output logic             frame_start_o
`endif
);
  localparam vtg_axis_t H_AX = '{active: H_ACTIVE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
  localparam vtg_axis_t V_AX = '{active: V_ACTIVE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
  if (FRAME_CNT_W < 1) begin : g_bad_fc
    $error("vga_timing_gen: FRAME_CNT_W must be >= 1");
  end
  logic [POS_W-1:0] w_h_cnt, w_v_cnt;
  logic w_h_wrap, w_h_sync, w_h_act, w_v_sync, w_v_act, w_unused_v_wrap, w_origin;
  logic [POS_W-1:0] r_hpos, r_vpos;
  logic r_hsync, r_vsync, r_de, r_line_start, r_frame_start;
  vtg_axis_counter #(.AX(H_AX), .W(POS_W)) u_h (
    .clk(clk_i), .rst(reset_i), .i_step(pix_en_i),
    .o_count(w_h_cnt), .o_wrap(w_h_wrap), .o_in_sync(w_h_sync), .o_in_active(w_h_act)
  );
  vtg_axis_counter #(.AX(V_AX), .W(POS_W)) u_v (
    .clk(clk_i), .rst(reset_i), .i_step(pix_en_i & w_h_wrap),
    .o_count(w_v_cnt), .o_wrap(w_unused_v_wrap), .o_in_sync(w_v_sync), .o_in_active(w_v_act)
  );
  assign w_origin = w_h_cnt == '0 && w_v_cnt == '0;
  // Outputs register the decode of the pre-increment counters; pulses drop while holding.
  always_ff @(posedge clk_i)
    if (reset_i) begin
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_de          <= 1'b0;
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pix_en_i) begin
      r_hsync       <= w_h_sync ~^ H_SYNC_POL;
      r_vsync       <= w_v_sync ~^ V_SYNC_POL;
      r_de          <= w_h_act & w_v_act;
      r_hpos        <= w_h_cnt;
      r_vpos        <= w_v_cnt;
      r_line_start  <= w_h_cnt == '0;
      r_frame_start <= w_origin;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  assign hsync_o       = r_hsync;
  assign vsync_o       = r_vsync;
  assign de_o          = r_de;
  assign hpos_o        = r_hpos;
  assign vpos_o        = r_vpos;
  assign line_start_o  = r_line_start;
  assign frame_start_o = r_frame_start;
`ifdef VTG_FRAME_COUNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  always_ff @(posedge clk_i)
    if (reset_i) r_frame_cnt <= '0;
    else if (pix_en_i && w_origin) r_frame_cnt <= r_frame_cnt + 1'b1;
  assign frame_cnt_o = r_frame_cnt;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench over three timing configurations of vga_timing_gen.
module tb_vga_timing_gen;
  typedef struct packed {
    logic hs, vs, de;
    logic [9:0] hp, vp;
    logic ls, fs;
    logic [7:0] fc;
  } exp_t;
  // DUT0 default 640x480, DUT1 tiny active-high 4/1/1/1 x 3/1/1/1, DUT2 small strobed every 4th clk
  int HA[3] = '{640, 4, 8};
  int HF[3] = '{16, 1, 2};
  int HS[3] = '{96, 1, 3};
  int HB[3] = '{48, 1, 2};
  int VA[3] = '{480, 3, 4};
  int VF[3] = '{10, 1, 1};
  int VS[3] = '{2, 1, 2};
  int VB[3] = '{33, 1, 1};
  bit POL[3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] FCM[3] = '{8'hff, 8'h03, 8'hff};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] pen = '0;
  logic [2:0] due = '0;
  logic armed = 1'b0;
  logic hs[3], vs[3], de[3], ls[3], fs[3];
  logic [9:0] hp[3], vp[3];
  logic [7:0] fc0, fc2;
  logic [1:0] fc1;
  exp_t act[3];
  exp_t q[3][$];
  exp_t last[3];
  int mh[3], mv[3];
  logic [7:0] mfc[3];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  vga_timing_gen dut0 (
    .clk_i(clk), .reset_i(rst), .pix_en_i(pen[0]), .hsync_o(hs[0]), .vsync_o(vs[0]),
    .de_o(de[0]), .hpos_o(hp[0]), .vpos_o(vp[0]), .line_start_o(ls[0]),
`ifdef VTG_FRAME_COUNT_EN
    .frame_cnt_o(fc0),
`endif
    .frame_start_o(fs[0])
  );
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .FRAME_CNT_W(2)
  ) dut1 (
    .clk_i(clk), .reset_i(rst), .pix_en_i(pen[1]), .hsync_o(hs[1]), .vsync_o(vs[1]),
    .de_o(de[1]), .hpos_o(hp[1]), .vpos_o(vp[1]), .line_start_o(ls[1]),
`ifdef VTG_FRAME_COUNT_EN
    .frame_cnt_o(fc1),
`endif
    .frame_start_o(fs[1])
  );
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut2 (
    .clk_i(clk), .reset_i(rst), .pix_en_i(pen[2]), .hsync_o(hs[2]), .vsync_o(vs[2]),
    .de_o(de[2]), .hpos_o(hp[2]), .vpos_o(vp[2]), .line_start_o(ls[2]),
`ifdef VTG_FRAME_COUNT_EN
    .frame_cnt_o(fc2),
`endif
    .frame_start_o(fs[2])
  );
`ifndef VTG_FRAME_COUNT_EN
  assign fc0 = '0;
  assign fc1 = '0;
  assign fc2 = '0;
`endif
  assign act[0] = '{hs[0], vs[0], de[0], hp[0], vp[0], ls[0], fs[0], fc0};
  assign act[1] = '{hs[1], vs[1], de[1], hp[1], vp[1], ls[1], fs[1], {6'b0, fc1}};
  assign act[2] = '{hs[2], vs[2], de[2], hp[2], vp[2], ls[2], fs[2], fc2};

  function automatic exp_t reset_exp(int k);
    return '{~POL[k], ~POL[k], 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 8'd0};
  endfunction

  // Reference decode of the model position, then advance the model raster.
  function automatic exp_t strobe_exp(int k);
    exp_t e;
    int hl = HA[k] + HF[k], vl = VA[k] + VF[k];
    e.hs = (mh[k] >= hl && mh[k] < hl + HS[k]) ? POL[k] : ~POL[k];
    e.vs = (mv[k] >= vl && mv[k] < vl + VS[k]) ? POL[k] : ~POL[k];
    e.de = mh[k] < HA[k] && mv[k] < VA[k];
    e.hp = 10'(mh[k]);
    e.vp = 10'(mv[k]);
    e.ls = mh[k] == 0;
    e.fs = mh[k] == 0 && mv[k] == 0;
`ifdef VTG_FRAME_COUNT_EN
    if (e.fs) mfc[k] = (mfc[k] + 8'd1) & FCM[k];
`endif
    e.fc = mfc[k];
    if (mh[k] == hl + HS[k] + HB[k] - 1) begin
      mh[k] = 0;
      mv[k] = (mv[k] == vl + VS[k] + VB[k] - 1) ? 0 : mv[k] + 1;
    end else mh[k] = mh[k] + 1;
    return e;
  endfunction

  task automatic step(input logic r, input logic [2:0] p);
    logic [2:0] d;
    rst = r;
    pen = p;
    for (int k = 0; k < 3; k++) begin
      d[k] = r | p[k];
      if (r) begin
        mh[k] = 0;
        mv[k] = 0;
        mfc[k] = 8'd0;
        q[k].push_back(reset_exp(k));
      end else if (p[k]) q[k].push_back(strobe_exp(k));
    end
    @(posedge clk);
    due = d;
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (armed)
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (due[k] && q[k].size() == 0) begin
          $display("FAIL dut%0d scoreboard_empty t=%0t got=%h", k, $time, act[k]);
        end else begin
          if (due[k]) e = q[k].pop_front();
          else begin
            e = last[k];
            e.ls = 1'b0;
            e.fs = 1'b0;
          end
          if (act[k] === e) n_pass++;
          else $display("FAIL dut%0d outputs t=%0t got hs=%b vs=%b de=%b h=%0d v=%0d ls=%b fs=%b fc=%0d exp hs=%b vs=%b de=%b h=%0d v=%0d ls=%b fs=%b fc=%0d",
                        k, $time, act[k].hs, act[k].vs, act[k].de, act[k].hp, act[k].vp, act[k].ls, act[k].fs, act[k].fc,
                        e.hs, e.vs, e.de, e.hp, e.vp, e.ls, e.fs, e.fc);
          last[k] = e;
        end
      end
  end

  initial begin
    int cyc = 0;
    step(1'b1, 3'b000);
    armed = 1'b1;
    step(1'b1, 3'b111);
    step(1'b0, 3'b000);
    for (int i = 0; i < 2500; i++) begin
      step(1'b0, {cyc % 4 == 0, 2'b11});
      cyc++;
    end
    for (int i = 0; i < 20; i++) step(1'b0, 3'b000);
    // Advance DUT0 to mid-line 300 of a later line, then reset mid-frame.
    for (int i = 0; i < 1000 && mh[0] != 300; i++) begin
      step(1'b0, {cyc % 4 == 0, 2'b11});
      cyc++;
    end
    step(1'b1, 3'b111);
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, {cyc % 4 == 0, 2'b11});
      cyc++;
    end
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (q[k].size() == 0) n_pass++;
      else $display("FAIL dut%0d leftover_expected got=%0d exp=0", k, q[k].size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
